// File: rtl/spike_pkg.sv
// Shared definitions for the spike gate datapath.
//   MODE_NZ / MODE_THR : detector mode encodings for thr_mode
//   clog2              : ceiling log2, used for the sum width
//   cnt_width          : refractory counter width, never below 1 bit
package spike_pkg;

  localparam logic MODE_NZ  = 1'b0;
  localparam logic MODE_THR = 1'b1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Counter width for a refractory length; a zero-length refractory
  // still gets a 1-bit counter so the register is never zero-width.
  function automatic int cnt_width(input int refrac);
    int w;
    w = clog2(refrac + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spike_gate_ch.sv
// One spike channel: fire detector, refractory counter and gate register.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : timestep beat strobe
//   thr_mode     : MODE_NZ (act != 0) or MODE_THR (act >= thr)
//   thr, act, wt : threshold, this channel's activity and weight
//   spike        : registered fire flag
//   gated        : registered weight, zero unless the channel fired
//   refrac_busy  : refractory counter nonzero (combinational from counter)
module spike_gate_ch
  import spike_pkg::*;
#(
  parameter int DW     = 4,
  parameter int WW     = 4,
  parameter int REFRAC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          thr_mode,
  input  logic [DW-1:0] thr,
  input  logic [DW-1:0] act,
  input  logic [WW-1:0] wt,
  output logic          spike,
  output logic [WW-1:0] gated,
  output logic          refrac_busy
);

  localparam int            CW          = cnt_width(REFRAC);
  localparam logic [CW-1:0] REFRAC_LOAD = CW'(REFRAC);

  logic          cand_s;
  logic          fire_s;
  logic [CW-1:0] cnt_r;
  logic          spike_r;
  logic [WW-1:0] gated_r;

  // Candidate detection for the selected mode.
  always_comb begin
    cand_s = 1'b0;
    case (thr_mode)
      MODE_NZ:  cand_s = (act != {DW{1'b0}});
      MODE_THR: cand_s = (act >= thr);
      default:  cand_s = 1'b0;
    endcase
  end

  // A channel only fires on a valid beat with its refractory window closed.
  assign fire_s = in_valid & cand_s & (cnt_r == {CW{1'b0}});

  // Refractory counter: advances on valid beats only, idle cycles freeze it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (in_valid) begin
      if (fire_s) begin
        cnt_r <= REFRAC_LOAD;
      end else if (cnt_r != {CW{1'b0}}) begin
        cnt_r <= cnt_r - CW'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage-1 register: fire flag and the weight sampled on the same beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_r <= 1'b0;
      gated_r <= {WW{1'b0}};
    end else begin
      spike_r <= fire_s;
      gated_r <= fire_s ? wt : {WW{1'b0}};
    end
  end

  assign spike       = spike_r;
  assign gated       = gated_r;
  assign refrac_busy = (cnt_r != {CW{1'b0}});

endmodule

// File: rtl/spike_gate_array.sv
// NCH-channel spike detector and weight gate with a summing second stage.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : timestep beat strobe for act/wt
//   thr_mode, thr   : detector mode and threshold, sampled per beat
//   act, wt         : packed per-channel activity and weight
//   spike, gated    : stage-1 fire flags and gated weights
//   gate_valid      : stage-1 holds a beat result
//   refrac_busy     : per-channel refractory counter nonzero
//   sum, sum_valid  : stage-2 sum of gated weights and its valid
module spike_gate_array
  import spike_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DW     = 4,
  parameter int WW     = 4,
  parameter int REFRAC = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         thr_mode,
  input  logic [DW-1:0]                thr,
  input  logic [NCH*DW-1:0]            act,
  input  logic [NCH*WW-1:0]            wt,
  output logic [NCH-1:0]               spike,
  output logic [NCH*WW-1:0]            gated,
  output logic                         gate_valid,
  output logic [NCH-1:0]               refrac_busy,
  output logic [WW+clog2(NCH)-1:0]     sum,
  output logic                         sum_valid
);

  localparam int SUMW = WW + clog2(NCH);

  logic [NCH-1:0]    spike_s;
  logic [NCH*WW-1:0] gated_s;
  logic              gate_valid_r;
  logic [SUMW-1:0]   sum_s;
  logic [SUMW-1:0]   sum_r;
  logic              sum_valid_r;

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      spike_gate_ch #(
        .DW     (DW),
        .WW     (WW),
        .REFRAC (REFRAC)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .thr_mode    (thr_mode),
        .thr         (thr),
        .act         (act[c*DW +: DW]),
        .wt          (wt[c*WW +: WW]),
        .spike       (spike_s[c]),
        .gated       (gated_s[c*WW +: WW]),
        .refrac_busy (refrac_busy[c])
      );
    end
  endgenerate

  // Adder over the gated fields, each zero-extended to the full sum width.
  always_comb begin
    sum_s = {SUMW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      sum_s = sum_s + SUMW'(gated_s[i*WW +: WW]);
    end
  end

  // Stage-1 valid tracks in_valid one clock behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_valid_r <= 1'b0;
    end else begin
      gate_valid_r <= in_valid;
    end
  end

  // Stage-2 register: sum only loads on a valid stage-1 result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= {SUMW{1'b0}};
      sum_valid_r <= 1'b0;
    end else begin
      sum_r       <= gate_valid_r ? sum_s : {SUMW{1'b0}};
      sum_valid_r <= gate_valid_r;
    end
  end

  assign spike      = spike_s;
  assign gated      = gated_s;
  assign gate_valid = gate_valid_r;
  assign sum        = sum_r;
  assign sum_valid  = sum_valid_r;

endmodule

// File: tb/tb_spike_gate_array.sv
// Self-checking bench for spike_gate_array: directed test-plan scenarios plus
// randomized beats, checked against a beat-index based reference model.
module tb_spike_gate_array;

  localparam int NCH    = 4;
  localparam int DW     = 4;
  localparam int WW     = 4;
  localparam int REFRAC = 2;
  localparam int SUMW   = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              thr_mode;
  logic [DW-1:0]     thr;
  logic [NCH*DW-1:0] act;
  logic [NCH*WW-1:0] wt;
  logic [NCH-1:0]    spike;
  logic [NCH*WW-1:0] gated;
  logic              gate_valid;
  logic [NCH-1:0]    refrac_busy;
  logic [SUMW-1:0]   sum;
  logic              sum_valid;

  spike_gate_array #(
    .NCH    (NCH),
    .DW     (DW),
    .WW     (WW),
    .REFRAC (REFRAC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .thr_mode    (thr_mode),
    .thr         (thr),
    .act         (act),
    .wt          (wt),
    .spike       (spike),
    .gated       (gated),
    .gate_valid  (gate_valid),
    .refrac_busy (refrac_busy),
    .sum         (sum),
    .sum_valid   (sum_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: valid beats since reset and last firing beat.
  int vbeat;
  int last_fire [NCH];
  int e_spike   [NCH];
  int e_w       [NCH];
  int e_gv;
  int e_sum;
  int e_sv;

  int drv_a [NCH];
  int drv_w [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int av, input int wv);
    for (int c = 0; c < NCH; c++) begin
      drv_a[c] = av;
      drv_w[c] = wv;
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic cycle(input logic r, input logic v, input logic m, input int th);
    int  ns;
    int  busy;
    bit  cand;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    thr_mode = m;
    thr      = DW'(th);
    for (int c = 0; c < NCH; c++) begin
      act[c*DW +: DW] = DW'(drv_a[c]);
      wt[c*WW +: WW]  = WW'(drv_w[c]);
    end
    if (r) begin
      vbeat = 0;
      for (int c = 0; c < NCH; c++) begin
        last_fire[c] = -1;
        e_spike[c]   = 0;
        e_w[c]       = 0;
      end
      e_gv  = 0;
      e_sum = 0;
      e_sv  = 0;
    end else begin
      ns = 0;
      for (int c = 0; c < NCH; c++) ns += e_w[c];
      e_sum = (e_gv != 0) ? ns : 0;
      e_sv  = e_gv;
      if (v) vbeat++;
      for (int c = 0; c < NCH; c++) begin
        e_spike[c] = 0;
        e_w[c]     = 0;
        if (v) begin
          cand = m ? (drv_a[c] >= th) : (drv_a[c] != 0);
          if (cand && (last_fire[c] < 0 || (vbeat - last_fire[c]) > REFRAC)) begin
            e_spike[c]   = 1;
            e_w[c]       = drv_w[c];
            last_fire[c] = vbeat;
          end
        end
      end
      e_gv = v ? 1 : 0;
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      busy = (last_fire[c] >= 0 && (vbeat - last_fire[c]) < REFRAC) ? 1 : 0;
      check($sformatf("spike[%0d]", c), 32'(spike[c]), e_spike[c]);
      check($sformatf("gated[%0d]", c), 32'(gated[c*WW +: WW]), e_w[c]);
      check($sformatf("busy[%0d]", c), 32'(refrac_busy[c]), busy);
    end
    check("gate_valid", 32'(gate_valid), e_gv);
    check("sum", 32'(sum), e_sum);
    check("sum_valid", 32'(sum_valid), e_sv);
  endtask

  int seq_exp [5] = '{1, 0, 0, 1, 0};
  int busy_exp [5] = '{1, 1, 0, 1, 1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; thr_mode = 1'b0; thr = '0; act = '0; wt = '0;
    set_all(0, 0);

    // 1. Reset with valid beats of full activity.
    set_all(15, 15);
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("rst_outputs", {spike, gated, gate_valid, refrac_busy, sum, sum_valid}, 32'd0);

    // 2. Nonzero mode, act ch3..ch0 = {0,3,0,1}, wt = {5,6,7,8}.
    set_all(0, 0);
    drv_a[0] = 1; drv_a[1] = 0; drv_a[2] = 3; drv_a[3] = 0;
    drv_w[0] = 8; drv_w[1] = 7; drv_w[2] = 6; drv_w[3] = 5;
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("nz_spike", 32'(spike), 32'h5);
    check("nz_gated", 32'(gated), 32'h0608);
    set_all(0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("nz_sum", 32'(sum), 32'd14);
    check("nz_sum_valid", 32'(sum_valid), 32'd1);

    // 3. Refractory on ch0, back-to-back and with idle gap after beat 1.
    cycle(1'b1, 1'b0, 1'b0, 0);
    drv_a[0] = 1; drv_w[0] = 3;
    for (int b = 0; b < 5; b++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      check($sformatf("refrac_seq%0d", b), 32'(spike[0]), seq_exp[b]);
      check($sformatf("refrac_busy%0d", b), 32'(refrac_busy[0]), busy_exp[b]);
    end
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int b = 0; b < 5; b++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      check($sformatf("gap_seq%0d", b), 32'(spike[0]), seq_exp[b]);
      if (b == 0) begin
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 0);
        check("gap_busy_hold", 32'(refrac_busy[0]), 32'd1);
      end
    end

    // 4. Threshold mode: thr=8, act ch3..ch0 = {0,15,8,7}; then thr=0, act 0.
    cycle(1'b1, 1'b0, 1'b0, 0);
    drv_a[0] = 7; drv_a[1] = 8; drv_a[2] = 15; drv_a[3] = 0;
    cycle(1'b0, 1'b1, 1'b1, 8);
    check("thr_spike", 32'(spike), 32'h6);
    cycle(1'b1, 1'b0, 1'b0, 0);
    set_all(0, 2);
    cycle(1'b0, 1'b1, 1'b1, 0);
    check("thr0_spike", 32'(spike), 32'hF);

    // 5. Full-scale sum.
    cycle(1'b1, 1'b0, 1'b0, 0);
    set_all(15, 15);
    cycle(1'b0, 1'b1, 1'b0, 0);
    set_all(0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("full_sum", 32'(sum), 32'd60);

    // 6. Reset mid-operation flushes the pipe and clears the counter.
    cycle(1'b1, 1'b0, 1'b0, 0);
    drv_a[0] = 1; drv_w[0] = 9;
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("mid_rst_busy", 32'(refrac_busy), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("mid_rst_sum_valid", 32'(sum_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    check("mid_rst_refire", 32'(spike[0]), 32'd1);

    // Randomized beats with occasional resets and mode changes.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        drv_a[c] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
        drv_w[c] = int'($urandom_range(0, 15));
      end
      cycle(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
